// File: rtl/io_bus_sequencer.sv
// IO bus sequencer: turns a held decoder IO load/store request into a
// SETUP/ACCESS/DONE peripheral handshake, stalling the CPU until it retires.
module io_bus_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              io_err,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_wdata,
  output logic              dev_rd,
  output logic              dev_wr,
  input  logic              dev_ack,
  input  logic [DATA_W-1:0] dev_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              op_rd_q, op_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req;
  logic              hit_timeout;

  assign req         = io_read | io_write;
  assign hit_timeout = (cnt_q == TIMEOUT_C);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (dev_ack || hit_timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack is checked before the timeout so an ack on the last allowed cycle succeeds.
  always_comb begin
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_rd_d = io_read;
        end
      end
      SETUP:  cnt_d = 8'd1;
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (dev_ack) begin
          if (op_rd_q) rdata_d = dev_rdata;
        end else if (hit_timeout) begin
          err_d = 1'b1;
          if (op_rd_q) rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= 8'd0;
      op_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    dev_rd    = 1'b0;
    dev_wr    = 1'b0;
    cpu_stall = 1'b0;
    if (state_q == ACCESS) begin
      dev_rd = op_rd_q;
      dev_wr = ~op_rd_q;
    end
    if (!reset && req && state_q != DONE) cpu_stall = 1'b1;
  end

  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign io_err    = err_q;

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Directed bench for io_bus_sequencer: expected per-access results are queued
// when a request is driven and compared when the DONE cycle is reached.
module tb_io_bus_sequencer;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_read = 1'b0;
  logic          io_write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          cpu_stall;
  logic [DW-1:0] rdata;
  logic          io_err;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata;
  logic          dev_rd;
  logic          dev_wr;
  logic          dev_ack = 1'b0;
  logic [DW-1:0] dev_rdata = '0;

  io_bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_read   (io_read),
    .io_write  (io_write),
    .addr      (addr),
    .wdata     (wdata),
    .cpu_stall (cpu_stall),
    .rdata     (rdata),
    .io_err    (io_err),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rd    (dev_rd),
    .dev_wr    (dev_wr),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            stall;
    int            rd_n;
    int            wr_n;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] model_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; b2b means the current cycle is the previous access's DONE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int ack_at, input logic [DW-1:0] rdv,
                            input bit noise, input bit b2b);
    exp_t e;
    exp_t got;
    int   stall_n = 0;
    int   rd_n = 0;
    int   wr_n = 0;
    int   err_n = 0;
    int   acc = 0;
    int   len;
    bit   done = 0;
    e.err   = (ack_at == 0);
    len     = e.err ? TO : ack_at;
    e.stall = 2 + len;
    e.rd_n  = rd ? len : 0;
    e.wr_n  = rd ? 0 : len;
    if (rd) e.rdata = e.err ? '0 : rdv;
    else    e.rdata = model_rdata;
    model_rdata = e.rdata;
    sb.push_back(e);

    io_read = rd; io_write = wr; addr = a; wdata = wd; dev_rdata = rdv;
    if (!b2b) begin
      #1;
      if (cpu_stall) stall_n++;
      dev_ack = noise;
    end
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      if (io_err) err_n++;
      if (dev_rd) rd_n++;
      if (dev_wr) wr_n++;
      if (cpu_stall) stall_n++;
      else done = 1;
      if (dev_rd | dev_wr) begin
        acc++;
        dev_ack = (ack_at != 0 && acc == ack_at);
      end else begin
        dev_ack = noise && !done;
      end
    end
    dev_ack = 1'b0;

    got = sb.pop_front();
    check({tag, ".done"},     32'(done), 32'd1);
    check({tag, ".stall_n"},  32'(stall_n), 32'(got.stall));
    check({tag, ".rd_n"},     32'(rd_n), 32'(got.rd_n));
    check({tag, ".wr_n"},     32'(wr_n), 32'(got.wr_n));
    check({tag, ".err_n"},    32'(err_n), 32'(got.err));
    check({tag, ".rdata"},    32'(rdata), 32'(got.rdata));
    check({tag, ".strobe_done"}, 32'({dev_rd, dev_wr}), 32'd0);
    check({tag, ".dev_addr"}, 32'(dev_addr), 32'(a));
    if (!rd) check({tag, ".dev_wdata"}, 32'(dev_wdata), 32'(wd));
  endtask

  task automatic idle(input int n);
    io_read = 1'b0; io_write = 1'b0;
    repeat (n) @(negedge clock);
    check("idle.stall", 32'(cpu_stall), 32'd0);
  endtask

  initial begin
    int rd_seen;

    // Reset with a request pending: stall must stay low.
    reset = 1'b1; io_read = 1'b1;
    repeat (3) @(negedge clock);
    check("rst.stall",     32'(cpu_stall), 32'd0);
    check("rst.rdata",     32'(rdata), 32'd0);
    check("rst.io_err",    32'(io_err), 32'd0);
    check("rst.dev_rd",    32'(dev_rd), 32'd0);
    check("rst.dev_wr",    32'(dev_wr), 32'd0);
    check("rst.dev_addr",  32'(dev_addr), 32'd0);
    check("rst.dev_wdata", 32'(dev_wdata), 32'd0);
    io_read = 1'b0; reset = 1'b0;
    @(negedge clock);

    run_access("rd_ack1",    1, 0, 10'h3F0, 16'h0000, 1,  16'h1234, 0, 0); idle(2);
    run_access("wr_ack4",    0, 1, 10'h3C0, 16'hA5A5, 4,  16'h7777, 0, 0); idle(1);
    run_access("rd_tmo",     1, 0, 10'h155, 16'h0000, 0,  16'hFFFF, 0, 0); idle(1);
    run_access("rd_ack15",   1, 0, 10'h2AA, 16'h0000, 15, 16'hBEEF, 0, 0); idle(1);
    run_access("rd_wr_both", 1, 1, 10'h001, 16'hDEAD, 2,  16'h5A5A, 0, 0); idle(1);
    run_access("b2b_wr",     0, 1, 10'h3FF, 16'h0F0F, 1,  16'h0000, 1, 0);
    run_access("b2b_rd",     1, 0, 10'h000, 16'h0000, 3,  16'hC3C3, 1, 1); idle(1);

    // Abort a read in its second ACCESS cycle.
    io_read = 1'b1; io_write = 1'b0; addr = 10'h123; dev_rdata = 16'h9999;
    rd_seen = 0;
    for (int c = 0; c < 10 && rd_seen < 2; c++) begin
      @(negedge clock);
      if (dev_rd) rd_seen++;
    end
    check("abort.reached", 32'(rd_seen), 32'd2);
    reset = 1'b1;
    #1;
    check("abort.stall_in_rst", 32'(cpu_stall), 32'd0);
    @(negedge clock);
    check("abort.dev_rd",   32'(dev_rd), 32'd0);
    check("abort.dev_wr",   32'(dev_wr), 32'd0);
    check("abort.io_err",   32'(io_err), 32'd0);
    check("abort.rdata",    32'(rdata), 32'd0);
    check("abort.dev_addr", 32'(dev_addr), 32'd0);
    check("abort.stall",    32'(cpu_stall), 32'd0);
    model_rdata = '0;
    reset = 1'b0;
    run_access("post_rst", 1, 0, 10'h123, 16'h0000, 1, 16'h4321, 0, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bus_sequencer.md
IO_BUS_SEQUENCER -- requirements
Module: io_bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, IO address bits forwarded to peripherals.
REQ-002 SHALL have parameter DATA_W, default 16, IO data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles without dev_ack (range 1..255).
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port io_read  in  1  decoder IO-load request (lw to IO page), held until instruction retires.
REQ-007 SHALL have port io_write  in  1  decoder IO-store request (sw to IO page), held until instruction retires.
REQ-008 SHALL have port addr  in  ADDR_W  low ALU-result bits of the IO address.
REQ-009 SHALL have port wdata  in  DATA_W  store data from register file.
REQ-010 SHALL have port cpu_stall  out  1  freezes PC/register write while high.
REQ-011 SHALL have port rdata  out  DATA_W  load data returned to write-back mux.
REQ-012 SHALL have port io_err  out  1  one-cycle pulse: access timed out.
REQ-013 SHALL have ports dev_addr out ADDR_W, dev_wdata out DATA_W, dev_rd out 1, dev_wr out 1  peripheral bus drive.
REQ-014 SHALL have ports dev_ack in 1, dev_rdata in DATA_W  peripheral completion and read data.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-016 IDLE: req = io_read|io_write; if req, latch addr, wdata, type (read if io_read) into dev_addr/dev_wdata/op register, go SETUP; else stay.
REQ-017 io_read and io_write both high in IDLE SHALL be treated as read; write data ignored.
REQ-018 SETUP: one cycle, dev_rd=dev_wr=0, dev_addr/dev_wdata stable; go ACCESS.
REQ-019 ACCESS: dev_rd=1 for read or dev_wr=1 for write; cycle counter starts at 1 on entry, increments each ACCESS cycle.
REQ-020 ACCESS with dev_ack=1: read captures dev_rdata into rdata same edge; write leaves rdata unchanged; go DONE.
REQ-021 ACCESS with dev_ack=0 and counter==TIMEOUT: go DONE, rdata<=0 for read, io_err pulses high during DONE cycle.
REQ-022 dev_ack=1 on the same cycle counter==TIMEOUT SHALL count as success (ack wins, no io_err).
REQ-023 DONE: strobes 0, cpu_stall 0 for exactly one cycle; go IDLE unconditionally without re-sampling req.
REQ-024 cpu_stall SHALL be combinational: 1 when req and state!=DONE, 0 otherwise, and 0 while reset high.
REQ-025 Latency with immediate ack: stall high 3 cycles (IDLE, SETUP, ACCESS), low in 4th (DONE).
REQ-026 dev_ack outside ACCESS SHALL be ignored; dev_addr/dev_wdata SHALL hold last latched value until next IDLE latch.
REQ-027 Back-to-back IO instructions: new req in IDLE after DONE SHALL start a new access with no idle gap beyond DONE.
REQ-028 rdata SHALL hold its value between accesses.

Reset
REQ-029 On reset: state IDLE, counter 0, rdata 0, io_err 0, dev_rd 0, dev_wr 0, dev_addr 0, dev_wdata 0.
REQ-030 Reset asserted mid-access (SETUP/ACCESS) SHALL abort: strobes low next edge, no io_err, rdata unchanged-to-0 per REQ-029.
REQ-031 After reset release with req high, a fresh access SHALL begin from IDLE on that cycle.

Verification
REQ-032 Read, ack on first ACCESS cycle, addr=0x3F0, dev_rdata=0x1234 -> stall high 3 cycles, dev_rd high 1 cycle, rdata=0x1234 in DONE, io_err 0.
REQ-033 Write addr=0x3C0 wdata=0xA5A5, ack after 4 ACCESS cycles -> dev_wr high 4 cycles, dev_wdata=0xA5A5, stall high 6 cycles, rdata unchanged.
REQ-034 Read, dev_ack never -> dev_rd high 15 cycles, DONE with rdata=0, io_err pulse 1 cycle, stall released.
REQ-035 Ack exactly on 15th ACCESS cycle -> success, rdata=dev_rdata, io_err 0.
REQ-036 io_read and io_write both high -> read performed, dev_wr never asserted.
REQ-037 Reset raised in 2nd ACCESS cycle -> next edge IDLE, strobes 0, io_err 0, rdata 0; stall 0 while reset high.
